register_bank: RTL and testbench

//  MIPS-style 32-entry general-purpose register file, the consumer of the RegDst-selected destination index.

---
 rtl/register_bank.sv | 64 ++++++
 tb/tb_register_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: 32-entry register file, r0 hardwired to zero, 2R/1W.
// Ports: clk, reset, RegWrite/WriteReg/WriteData, ReadReg1/2 -> ReadData1/2,
// LastWrValid/LastWrReg/WrCount. Optional same-cycle write bypass: RF_WRITE_BYPASS_EN.
module register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              LastWrValid,
  output logic [ADDR_W-1:0] LastWrReg,
  output logic [15:0]       WrCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // Writes to r0 are dropped entirely, including the debug trackers.
  assign wr_en = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      LastWrValid <= 1'b0;
      LastWrReg   <= '0;
      WrCount     <= '0;
    end else if (wr_en) begin
      regs[WriteReg] <= WriteData;
      LastWrValid    <= 1'b1;
      LastWrReg      <= WriteReg;
      WrCount        <= WrCount + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs[a];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && (a == WriteReg)) v = WriteData;
`endif
    // Gating on reset keeps a bypassed WriteData from leaking out.
    if (reset || (a == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    ReadData1 = rd(ReadReg1);
    ReadData2 = rd(ReadReg2);
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table vectors, directed corner cases and randomized
// traffic against an array model of the register file.
module tb_register_bank;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        LastWrValid;
  logic [4:0]  LastWrReg;
  logic [15:0] WrCount;

  int passed = 0;
  int total  = 0;

  // Reference model
  logic [31:0] m [32];
  int          mcnt;
  bit          mvalid;
  int          mlast;

  register_bank dut (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .LastWrValid(LastWrValid), .LastWrReg(LastWrReg), .WrCount(WrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ec;
    logic [4:0]  el;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  function automatic logic [31:0] mread(input int a);
    if (a == 0) return 32'h0;
    if (BYP && RegWrite && WriteReg != 0 && a == WriteReg)
      return WriteData;
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt = 0;
    mvalid = 0;
    mlast = 0;
  endtask

  task automatic model_write();
    if (RegWrite && WriteReg != 0) begin
      m[WriteReg] = WriteData;
      mcnt = (mcnt + 1) % 65536;
      mvalid = 1;
      mlast = WriteReg;
    end
  endtask

  task automatic idle();
    RegWrite = 1'b0;
    WriteReg = 5'd0;
    WriteData = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    model_reset();

    // 1. reads under reset, including a would-be bypass
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      RegWrite = 1'b1;
      WriteReg = 5'(i);
      WriteData = 32'h5555_0000 + 32'(i);
      #1;
      chk("rst_rd1", ReadData1, 32'h0);
      chk("rst_rd2", ReadData2, 32'h0);
    end
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'h0, LastWrValid}, 32'h0);
    chk("rst_cnt", {16'h0, WrCount}, 32'h0);
    chk("rst_last", {27'h0, LastWrReg}, 32'h0);

    // 2/3. table vectors, checked after the edge with RegWrite dropped
    tbl[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8, 5'd31,
               32'hDEADBEEF, 32'h0, 16'd1, 5'd8};
    tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd8, 5'd31,
               32'hDEADBEEF, 32'h12345678, 16'd2, 5'd31};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd31,
               32'h0, 32'h12345678, 16'd2, 5'd31};
    tbl[3] = '{1'b0, 5'd8,  32'h0, 5'd8, 5'd8,
               32'hDEADBEEF, 32'hDEADBEEF, 16'd2, 5'd31};
    tbl[4] = '{1'b1, 5'd8,  32'hCAFEF00D, 5'd8, 5'd0,
               32'hCAFEF00D, 32'h0, 16'd3, 5'd8};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      RegWrite = tbl[i].rw;
      WriteReg = tbl[i].wr;
      WriteData = tbl[i].wd;
      ReadReg1 = tbl[i].r1;
      ReadReg2 = tbl[i].r2;
      @(posedge clk);
      #1;
      idle();
      #1;
      chk("tbl_rd1", ReadData1, tbl[i].e1);
      chk("tbl_rd2", ReadData2, tbl[i].e2);
      chk("tbl_cnt", {16'h0, WrCount}, {16'h0, tbl[i].ec});
      chk("tbl_last", {27'h0, LastWrReg}, {27'h0, tbl[i].el});
      chk("tbl_valid", {31'h0, LastWrValid}, 32'h1);
    end

    // 4. same-cycle read/write of r5, and r0 never bypassed
    @(negedge clk);
    RegWrite = 1'b1;
    WriteReg = 5'd5;
    WriteData = 32'hA5A5A5A5;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd5;
    #1;
    chk("byp_pre", ReadData1, BYP ? 32'hA5A5A5A5 : 32'h0);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("byp_post", ReadData1, 32'hA5A5A5A5);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteReg = 5'd0;
    WriteData = 32'h77777777;
    ReadReg1 = 5'd0;
    #1;
    chk("byp_r0", ReadData1, 32'h0);
    @(posedge clk);
    #1;
    chk("byp_r0_cnt", {16'h0, WrCount}, 32'd4);

    // 5. reset between edges kills the pending write
    @(negedge clk);
    RegWrite = 1'b1;
    WriteReg = 5'd3;
    WriteData = 32'h1;
    @(posedge clk);
    #1;
    idle();
    ReadReg1 = 5'd3;
    #1;
    chk("r3_one", ReadData1, 32'h1);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteData = 32'h2;
    WriteReg = 5'd3;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_r3", ReadData1, 32'h0);
    chk("mid_rst_cnt", {16'h0, WrCount}, 32'h0);
    chk("mid_rst_valid", {31'h0, LastWrValid}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_r3", ReadData1, 32'h0);
    chk("post_rst_cnt", {16'h0, WrCount}, 32'h0);
    model_reset();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      RegWrite = ($urandom_range(0, 3) != 0);
      WriteReg = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadReg1 = ($urandom_range(0, 3) == 0) ? WriteReg
                                             : 5'($urandom_range(0, 31));
      ReadReg2 = ($urandom_range(0, 3) == 0) ? ReadReg1
                                             : 5'($urandom_range(0, 31));
      #1;
      chk("rnd_rd1", ReadData1, mread(ReadReg1));
      chk("rnd_rd2", ReadData2, mread(ReadReg2));
      @(posedge clk);
      model_write();
      #1;
      chk("rnd_cnt", {16'h0, WrCount}, 32'(mcnt));
      chk("rnd_valid", {31'h0, LastWrValid}, {31'h0, mvalid});
      chk("rnd_last", {27'h0, LastWrReg}, 32'(mlast));
    end

    // 6. counter wrap over 65537 writes to r1
    do_reset();
    ReadReg1 = 5'd1;
    for (int i = 1; i <= 65537; i++) begin
      @(negedge clk);
      RegWrite = 1'b1;
      WriteReg = 5'd1;
      WriteData = 32'h9000_0000 + 32'(i);
      @(posedge clk);
      model_write();
      if (i == 65535 || i == 65536) begin
        #1;
        chk("wrap_edge_cnt", {16'h0, WrCount}, 32'(mcnt));
      end
    end
    #1;
    idle();
    #1;
    chk("wrap_cnt", {16'h0, WrCount}, 32'h1);
    chk("wrap_r1", ReadData1, 32'h9000_0000 + 32'd65537);
    chk("wrap_last", {27'h0, LastWrReg}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
